data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Word-addressed data-memory target answering the core's load/store port over a
//  valid/ready request/response handshake with programmable wait states.
//  Replaces the zero-latency data memory so the core and its bus logic can be
//  exercised against a slow memory. One transaction is in flight at a time.
//  Byte strobes give sb/sh/sw support; out-of-range addresses are flagged.
// PARAMETERS
//  ADDR_WIDTH  10  word-address width on req_addr
//  DEPTH       1024  number of 32-bit words implemented (DEPTH <= 2**ADDR_WIDTH)
//  LATENCY     2   BUSY cycles between acceptance and response (legal 1..15)
// PORTS
//  clock      in   1   rising-edge clock
//  reset      in   1   synchronous, active-high reset
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept; high only in IDLE
//  req_write  in   1   1 = store, 0 = load
//  req_addr   in   ADDR_WIDTH  word address
//  req_wdata  in   32  store data
//  req_wstrb  in   4   byte-lane enables for stores (bit i -> wdata[8i+7:8i])
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   requester accepts response
//  rsp_rdata  out  32  load data (0 for stores and errors)
//  rsp_error  out  1   1 = req_addr >= DEPTH
// BEHAVIOUR
//  - States IDLE, BUSY, RESP; 4-bit wait counter.
//  - Reset (sampled at edge): state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0,
//    rsp_error=0; req_ready=1 from the first cycle after reset deasserts. Memory
//    array is not cleared. Reset in BUSY aborts: pending store never commits.
//  - IDLE: req_ready=1. req_valid sampled high at an edge -> latch write/addr/
//    wdata/wstrb, counter=LATENCY-1, go BUSY. req_valid low -> stay.
//  - BUSY: req_ready=0, rsp_valid=0. Counter decrements each edge; at the edge where
//    counter==0: perform access, load rsp_rdata/rsp_error, go RESP.
//  - Latency: handshake in cycle 0 -> BUSY cycles 1..LATENCY -> rsp_valid=1 in
//    cycle LATENCY+1.
//  - Store: each lane with wstrb[i]=1 written; others keep old value; wstrb=4'b0000
//    is a legal no-op store, still acknowledged. rsp_rdata=0.
//  - Load: rsp_rdata = mem[addr] as of the commit edge (includes prior stores).
//  - addr >= DEPTH: no array write, rsp_rdata=0, rsp_error=1; timing unchanged.
//  - RESP: rsp_valid=1, rsp_rdata/rsp_error held stable until rsp_ready sampled
//    high; then rsp_valid=0, rsp_rdata=0, rsp_error=0, go IDLE. req_ready=0 in
//    RESP, so a new request is taken no earlier than the cycle after the response
//    handshake (minimum transaction = LATENCY+2 cycles).
//  - Request inputs are don't-care outside IDLE; latched copies are used.
//  - rsp_ready high while not in RESP has no effect.
// TESTING
//  1 reset 3 cycles -> rsp_valid=0, rsp_rdata=0, rsp_error=0; req_ready=1 in the
//    cycle after release.
//  2 LATENCY=2: store addr 5 data 32'hDEADBEEF strb 4'hF, then load addr 5 with
//    rsp_ready=1 -> each response in cycle 3 after handshake; load returns
//    32'hDEADBEEF, rsp_error=0.
//  3 partial store addr 5 data 32'h000000AA strb 4'b0001 -> load addr 5 returns
//    32'hDEADBEAA; strb 4'b0000 store -> data unchanged, response still given.
//  4 load addr DEPTH (1024, ADDR_WIDTH=11) -> rsp_error=1, rsp_rdata=0; store to
//    same addr leaves addr 0 (alias) unchanged.
//  5 backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable,
//    req_ready=0 throughout; request held on req_valid not accepted until IDLE.
//  6 reset asserted in BUSY of a store to addr 7 (prior 32'h11111111) -> after
//    reset, load addr 7 returns 32'h11111111; LATENCY=1 sweep gives response
//    in cycle 2.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-addressed 32-bit data memory with a valid/ready request/response handshake
//   and a fixed, programmable number of wait states. One transaction is in flight at
//   a time. Stores honour per-byte strobes. Addresses at or beyond DEPTH are flagged
//   as errors and never touch the array.
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_write             1 = store, 0 = load
//   req_addr              word address
//   req_wdata/req_wstrb   store data and byte-lane enables
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             load data (0 for stores and errors)
//   rsp_error             address out of range
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error
);

  localparam int unsigned IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    error_q, error_d;

  logic [31:0]             mem_q [DEPTH];

  logic                    in_range;
  logic [IdxW-1:0]         mem_idx;
  logic                    commit;
  logic                    mem_we;

  assign in_range = 32'(addr_q) < DEPTH;
  assign mem_idx  = addr_q[IdxW-1:0];
  // The access happens on the edge that ends the last wait cycle.
  assign commit   = (state_q == StBusy) && (cnt_q == 4'd0);
  assign mem_we   = commit && write_q && in_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    error_d = error_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          cnt_d   = CntInit;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          error_d = !in_range;
          // Load sees the array before this edge, i.e. all earlier stores.
          rdata_d = (!write_q && in_range) ? mem_q[mem_idx] : 32'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
          rdata_d = 32'd0;
          error_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // Array is never cleared; reset only suppresses a store still in flight.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem_q[mem_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  // Instance A: LATENCY=2, 11-bit address so DEPTH itself is reachable.
  logic        a_req_valid, a_req_ready, a_req_write;
  logic [10:0] a_req_addr;
  logic [31:0] a_req_wdata;
  logic [3:0]  a_req_wstrb;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_error;
  logic [31:0] a_rsp_rdata;

  // Instance B: LATENCY=1.
  logic        b_req_valid, b_req_ready, b_req_write;
  logic [9:0]  b_req_addr;
  logic [31:0] b_req_wdata;
  logic [3:0]  b_req_wstrb;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_error;
  logic [31:0] b_rsp_rdata;

  data_mem_responder #(.ADDR_WIDTH(11), .DEPTH(1024), .LATENCY(2)) u_dut_a (
    .clock     (clock),
    .reset     (reset),
    .req_valid (a_req_valid),
    .req_ready (a_req_ready),
    .req_write (a_req_write),
    .req_addr  (a_req_addr),
    .req_wdata (a_req_wdata),
    .req_wstrb (a_req_wstrb),
    .rsp_valid (a_rsp_valid),
    .rsp_ready (a_rsp_ready),
    .rsp_rdata (a_rsp_rdata),
    .rsp_error (a_rsp_error)
  );

  data_mem_responder #(.ADDR_WIDTH(10), .DEPTH(1024), .LATENCY(1)) u_dut_b (
    .clock     (clock),
    .reset     (reset),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_write (b_req_write),
    .req_addr  (b_req_addr),
    .req_wdata (b_req_wdata),
    .req_wstrb (b_req_wstrb),
    .rsp_valid (b_rsp_valid),
    .rsp_ready (b_rsp_ready),
    .rsp_rdata (b_rsp_rdata),
    .rsp_error (b_rsp_error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic cur_rsp_valid(input bit sel);
    return sel ? b_rsp_valid : a_rsp_valid;
  endfunction

  function automatic logic cur_req_ready(input bit sel);
    return sel ? b_req_ready : a_req_ready;
  endfunction

  function automatic logic [31:0] cur_rdata(input bit sel);
    return sel ? b_rsp_rdata : a_rsp_rdata;
  endfunction

  function automatic logic cur_error(input bit sel);
    return sel ? b_rsp_error : a_rsp_error;
  endfunction

  task automatic drive_req(input bit sel, input bit vld, input bit wr, input logic [10:0] addr,
                           input logic [31:0] wd, input logic [3:0] st);
    if (sel) begin
      b_req_valid = vld; b_req_write = wr; b_req_addr = addr[9:0];
      b_req_wdata = wd;  b_req_wstrb = st;
    end else begin
      a_req_valid = vld; a_req_write = wr; a_req_addr = addr;
      a_req_wdata = wd;  a_req_wstrb = st;
    end
  endtask

  // Called in the handshake cycle (request already driven); counts cycles to rsp_valid.
  task automatic wait_rsp(input bit sel, input string tag, input int exp_lat,
                          input logic [31:0] exp_rdata, input logic exp_err);
    int n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        if (sel) b_req_valid = 1'b0;
        else     a_req_valid = 1'b0;
        check_eq({tag, "/busy_req_ready"}, 32'(cur_req_ready(sel)), 32'd0);
      end
    end while (!cur_rsp_valid(sel) && n < 20);
    check_eq({tag, "/latency"}, n, exp_lat);
    check_eq({tag, "/rdata"}, cur_rdata(sel), exp_rdata);
    check_eq({tag, "/error"}, 32'(cur_error(sel)), 32'(exp_err));
  endtask

  // Full transaction with rsp_ready high; ends back in IDLE.
  task automatic txn(input bit sel, input string tag, input bit wr, input logic [10:0] addr,
                     input logic [31:0] wd, input logic [3:0] st,
                     input logic [31:0] exp_rdata, input logic exp_err);
    drive_req(sel, 1'b1, wr, addr, wd, st);
    wait_rsp(sel, tag, sel ? 2 : 3, exp_rdata, exp_err);
    tick();
    check_eq({tag, "/rsp_valid_clr"}, 32'(cur_rsp_valid(sel)), 32'd0);
    check_eq({tag, "/rdata_clr"}, cur_rdata(sel), 32'd0);
    check_eq({tag, "/idle_req_ready"}, 32'(cur_req_ready(sel)), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, 11'd0, 32'd0, 4'd0);
    drive_req(1'b1, 1'b0, 1'b0, 11'd0, 32'd0, 4'd0);
    a_rsp_ready = 1'b1;
    b_rsp_ready = 1'b1;

    // Reset
    repeat (3) tick();
    check_eq("rst/rsp_valid", 32'(a_rsp_valid), 32'd0);
    check_eq("rst/rdata", a_rsp_rdata, 32'd0);
    check_eq("rst/error", 32'(a_rsp_error), 32'd0);
    reset = 1'b0;
    tick();
    check_eq("rst/req_ready_a", 32'(a_req_ready), 32'd1);
    check_eq("rst/req_ready_b", 32'(b_req_ready), 32'd1);

    // Full store / load
    txn(1'b0, "st5", 1'b1, 11'd5, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0);
    txn(1'b0, "ld5", 1'b0, 11'd5, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0);

    // Partial and empty strobes
    txn(1'b0, "st5_b0", 1'b1, 11'd5, 32'h000000AA, 4'b0001, 32'd0, 1'b0);
    txn(1'b0, "ld5_b0", 1'b0, 11'd5, 32'd0, 4'h0, 32'hDEADBEAA, 1'b0);
    txn(1'b0, "st5_nop", 1'b1, 11'd5, 32'h12345678, 4'b0000, 32'd0, 1'b0);
    txn(1'b0, "ld5_nop", 1'b0, 11'd5, 32'd0, 4'h0, 32'hDEADBEAA, 1'b0);

    // Out of range; addr 1024 must not alias onto addr 0
    txn(1'b0, "st0", 1'b1, 11'd0, 32'h0BADF00D, 4'hF, 32'd0, 1'b0);
    txn(1'b0, "ld_oor", 1'b0, 11'd1024, 32'd0, 4'h0, 32'd0, 1'b1);
    txn(1'b0, "st_oor", 1'b1, 11'd1024, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b1);
    txn(1'b0, "ld0_alias", 1'b0, 11'd0, 32'd0, 4'h0, 32'h0BADF00D, 1'b0);

    // Response backpressure with a new request held on req_valid
    a_rsp_ready = 1'b0;
    drive_req(1'b0, 1'b1, 1'b0, 11'd5, 32'd0, 4'h0);
    wait_rsp(1'b0, "bp_ld5", 3, 32'hDEADBEAA, 1'b0);
    drive_req(1'b0, 1'b1, 1'b1, 11'd6, 32'h66666666, 4'hF);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp/rsp_valid", 32'(a_rsp_valid), 32'd1);
      check_eq("bp/rdata", a_rsp_rdata, 32'hDEADBEAA);
      check_eq("bp/req_ready", 32'(a_req_ready), 32'd0);
    end
    a_rsp_ready = 1'b1;
    tick();
    check_eq("bp/rsp_valid_clr", 32'(a_rsp_valid), 32'd0);
    check_eq("bp/idle_req_ready", 32'(a_req_ready), 32'd1);
    wait_rsp(1'b0, "bp_held_st6", 3, 32'd0, 1'b0);
    tick();
    txn(1'b0, "ld6", 1'b0, 11'd6, 32'd0, 4'h0, 32'h66666666, 1'b0);

    // Reset in BUSY aborts a pending store
    txn(1'b0, "st7", 1'b1, 11'd7, 32'h11111111, 4'hF, 32'd0, 1'b0);
    drive_req(1'b0, 1'b1, 1'b1, 11'd7, 32'h22222222, 4'hF);
    tick();
    a_req_valid = 1'b0;
    check_eq("abort/busy_req_ready", 32'(a_req_ready), 32'd0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_eq("abort/rsp_valid", 32'(a_rsp_valid), 32'd0);
    check_eq("abort/req_ready", 32'(a_req_ready), 32'd1);
    txn(1'b0, "ld7", 1'b0, 11'd7, 32'd0, 4'h0, 32'h11111111, 1'b0);

    // LATENCY=1 instance
    txn(1'b1, "l1_st3", 1'b1, 11'd3, 32'hA5A5A5A5, 4'hF, 32'd0, 1'b0);
    txn(1'b1, "l1_ld3", 1'b0, 11'd3, 32'd0, 4'h0, 32'hA5A5A5A5, 1'b0);
    txn(1'b1, "l1_st3_hi", 1'b1, 11'd3, 32'h12340000, 4'b1100, 32'd0, 1'b0);
    txn(1'b1, "l1_ld3_hi", 1'b0, 11'd3, 32'd0, 4'h0, 32'h1234A5A5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
